// File: rtl/game_round_controller.sv
// Round sequencer for the dodge-the-blocks playfield: gates object motion, commands
// respawns and tracks lives, score and remaining round time.
module game_round_controller #(
    parameter int LIVES       = 3,
    parameter int ROUND_TICKS = 3000,
    parameter int HIT_TICKS   = 100,
    parameter int SCORE_DIV   = 10,
    parameter int SCORE_MAX   = 9999
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        tick,
    input  logic        launch,
    input  logic        collision,
    output logic        run,
    output logic        respawn,
    output logic        blink,
    output logic [2:0]  state,
    output logic [1:0]  lives,
    output logic [13:0] score,
    output logic [11:0] time_left
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PLAY = 3'd1,
        HIT  = 3'd2,
        OVER = 3'd3,
        WIN  = 3'd4
    } state_t;

    localparam logic [1:0]  LIVES_INIT = 2'(LIVES);
    localparam logic [11:0] TIME_INIT  = 12'(ROUND_TICKS);
    localparam logic [7:0]  HIT_INIT   = 8'(HIT_TICKS);
    localparam logic [7:0]  DIV_LAST   = 8'(SCORE_DIV - 1);
    localparam logic [13:0] SCORE_TOP  = 14'(SCORE_MAX);

    state_t     state_q;
    logic       launch_q;
    logic       launch_rise;
    logic [7:0] hit_cnt;
    logic [7:0] score_div;

    // tick and launch_rise are single-cycle events; collision is a level sampled every clock.
    assign launch_rise = launch & ~launch_q;
    assign state       = state_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            launch_q  <= 1'b0;
            run       <= 1'b0;
            respawn   <= 1'b0;
            blink     <= 1'b0;
            lives     <= LIVES_INIT;
            score     <= '0;
            time_left <= TIME_INIT;
            hit_cnt   <= '0;
            score_div <= '0;
        end else begin
            launch_q <= launch;
            respawn  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (launch_rise) begin
                        state_q   <= PLAY;
                        run       <= 1'b1;
                        respawn   <= 1'b1;
                        blink     <= 1'b0;
                        lives     <= LIVES_INIT;
                        score     <= '0;
                        time_left <= TIME_INIT;
                        hit_cnt   <= '0;
                        score_div <= '0;
                    end
                end
                PLAY: begin
                    if (collision) begin
                        state_q <= HIT;
                        run     <= 1'b0;
                        lives   <= lives - 2'd1;
                        hit_cnt <= HIT_INIT;
                        blink   <= 1'b0;
                        // A hit right after the start pulse would otherwise give a 2-cycle respawn.
                        respawn <= ~respawn;
                    end else if (tick) begin
                        time_left <= time_left - 12'd1;
                        if (score_div == DIV_LAST) begin
                            score_div <= '0;
                            if (score < SCORE_TOP) begin
                                score <= score + 14'd1;
                            end
                        end else begin
                            score_div <= score_div + 8'd1;
                        end
                        if (time_left == 12'd1) begin
                            state_q <= WIN;
                            run     <= 1'b0;
                        end
                    end
                end
                HIT: begin
                    if (tick) begin
                        if (hit_cnt == 8'd1) begin
                            hit_cnt <= '0;
                            blink   <= 1'b0;
                            if (lives == 2'd0) begin
                                state_q <= OVER;
                                run     <= 1'b0;
                            end else begin
                                state_q <= PLAY;
                                run     <= 1'b1;
                            end
                        end else begin
                            hit_cnt <= hit_cnt - 8'd1;
                            blink   <= ~blink;
                        end
                    end
                end
                OVER, WIN: begin
                    run <= 1'b0;
                    if (launch_rise) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    run     <= 1'b0;
                    blink   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_round_controller.sv
// Directed bench for game_round_controller with a small parameter set (2 lives, 5-tick round).
module tb_game_round_controller;

    logic        clock;
    logic        reset_n;
    logic        tick;
    logic        launch;
    logic        collision;
    logic        run;
    logic        respawn;
    logic        blink;
    logic [2:0]  state;
    logic [1:0]  lives;
    logic [13:0] score;
    logic [11:0] time_left;

    int n_checks = 0;
    int n_errors = 0;

    game_round_controller #(
        .LIVES(2), .ROUND_TICKS(5), .HIT_TICKS(3), .SCORE_DIV(2), .SCORE_MAX(9999)
    ) dut (
        .clock(clock), .reset_n(reset_n), .tick(tick), .launch(launch),
        .collision(collision), .run(run), .respawn(respawn), .blink(blink),
        .state(state), .lives(lives), .score(score), .time_left(time_left)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // drivers: inputs change 1 time unit after the rising edge, checks are made there too
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic tick_once();
        repeat (3) cyc();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0; tick = 1'b0; launch = 1'b0; collision = 1'b0;
        repeat (2) cyc();
        check("rst_state", 16'(state), 16'd0);
        check("rst_run", 16'(run), 16'd0);
        check("rst_respawn", 16'(respawn), 16'd0);
        check("rst_blink", 16'(blink), 16'd0);
        check("rst_lives", 16'(lives), 16'd2);
        check("rst_score", 16'(score), 16'd0);
        check("rst_time", 16'(time_left), 16'd5);
        reset_n = 1'b1;
        repeat (2) cyc();
        check("idle_hold", 16'(state), 16'd0);

        // start
        launch = 1'b1; cyc();
        check("start_state", 16'(state), 16'd1);
        check("start_run", 16'(run), 16'd1);
        check("start_respawn", 16'(respawn), 16'd1);
        check("start_lives", 16'(lives), 16'd2);
        cyc();
        check("start_respawn_end", 16'(respawn), 16'd0);
        launch = 1'b0;

        // win: five clean ticks
        tick_once(); check("win_t1", 16'(time_left), 16'd4);
        tick_once(); check("win_t2", 16'(time_left), 16'd3);
        check("win_score1", 16'(score), 16'd1);
        tick_once(); check("win_t3", 16'(time_left), 16'd2);
        tick_once(); check("win_t4", 16'(time_left), 16'd1);
        check("win_pre_state", 16'(state), 16'd1);
        tick_once();
        check("win_t5", 16'(time_left), 16'd0);
        check("win_state", 16'(state), 16'd4);
        check("win_score", 16'(score), 16'd2);
        check("win_run", 16'(run), 16'd0);
        collision = 1'b1; cyc(); collision = 1'b0;
        check("win_coll_ignored", 16'(state), 16'd4);
        launch = 1'b1; cyc();
        check("win_to_idle", 16'(state), 16'd0);
        launch = 1'b0; cyc();

        // hit and recover
        launch = 1'b1; cyc();
        check("g2_state", 16'(state), 16'd1);
        launch = 1'b0; cyc();
        tick_once();
        check("g2_time", 16'(time_left), 16'd4);
        collision = 1'b1; cyc();
        check("hit_state", 16'(state), 16'd2);
        check("hit_lives", 16'(lives), 16'd1);
        check("hit_respawn", 16'(respawn), 16'd1);
        check("hit_blink0", 16'(blink), 16'd0);
        check("hit_run", 16'(run), 16'd0);
        cyc();
        check("hit_respawn_end", 16'(respawn), 16'd0);
        check("hit_coll_ignored", 16'(lives), 16'd1);
        collision = 1'b0;
        launch = 1'b1; cyc(); launch = 1'b0;
        check("hit_launch_ignored", 16'(state), 16'd2);
        tick_once(); check("hit_blink1", 16'(blink), 16'd1);
        tick_once(); check("hit_blink2", 16'(blink), 16'd0);
        check("hit_still", 16'(state), 16'd2);
        tick_once();
        check("recover_state", 16'(state), 16'd1);
        check("recover_run", 16'(run), 16'd1);
        check("recover_blink", 16'(blink), 16'd0);
        check("recover_time", 16'(time_left), 16'd4);
        check("recover_score", 16'(score), 16'd0);

        // run down to time_left=1, then collision and tick together
        tick_once(); tick_once(); tick_once();
        check("sim_pre_time", 16'(time_left), 16'd1);
        check("sim_pre_score", 16'(score), 16'd2);
        repeat (3) cyc();
        collision = 1'b1; tick = 1'b1; cyc();
        collision = 1'b0; tick = 1'b0;
        check("sim_state", 16'(state), 16'd2);
        check("sim_time", 16'(time_left), 16'd1);
        check("sim_lives", 16'(lives), 16'd0);
        check("sim_score", 16'(score), 16'd2);

        // game over
        tick_once(); tick_once();
        check("over_pre", 16'(state), 16'd2);
        tick_once();
        check("over_state", 16'(state), 16'd3);
        check("over_run", 16'(run), 16'd0);
        check("over_lives", 16'(lives), 16'd0);
        check("over_time", 16'(time_left), 16'd1);
        collision = 1'b1; cyc(); collision = 1'b0;
        check("over_coll_ignored", 16'(state), 16'd3);
        launch = 1'b1; cyc();
        check("over_to_idle", 16'(state), 16'd0);
        launch = 1'b0; cyc();

        // reset in the middle of HIT
        launch = 1'b1; cyc(); launch = 1'b0; cyc();
        collision = 1'b1; cyc(); collision = 1'b0;
        check("mid_hit_state", 16'(state), 16'd2);
        tick_once();
        check("mid_hit_blink", 16'(blink), 16'd1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_state", 16'(state), 16'd0);
        check("arst_run", 16'(run), 16'd0);
        check("arst_blink", 16'(blink), 16'd0);
        cyc();
        reset_n = 1'b1;
        cyc();
        check("rel_lives", 16'(lives), 16'd2);
        check("rel_score", 16'(score), 16'd0);
        check("rel_respawn", 16'(respawn), 16'd0);
        check("rel_state", 16'(state), 16'd0);

        // key held through reset release counts as one rise
        reset_n = 1'b0; launch = 1'b1; cyc();
        reset_n = 1'b1; cyc();
        check("held_state", 16'(state), 16'd1);
        check("held_respawn", 16'(respawn), 16'd1);
        cyc();
        check("held_no_retrigger", 16'(respawn), 16'd0);
        launch = 1'b0; cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
